mips_mc_control: RTL and testbench

- Multi-cycle MIPS control FSM that drives the ALU's alu_op/alu_funct inputs and consumes its ZERO flag.
- Sequences fetch/decode/execute/memory/writeback for R-type (and, or, add, sub, mul), lw, sw, beq, j and addi.
- Stalls on a memory-ready handshake, counts retired instructions, and halts on an illegal opcode or funct.

---
 rtl/mips_mc_control.sv | 182 ++++++++++++++++++
 tb/tb_mips_mc_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory-ready stalls, retired-instruction counter, sticky halt on illegal instructions.
module mips_mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             ZERO,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic [5:0]       alu_funct,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADDR= 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC    = 4'd6,
        S_R_WB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    state_t           state_q, state_d;
    logic [5:0]       funct_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             funct_ok;
    logic             pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

    assign funct_ok = (funct == 6'b100100) || (funct == 6'b100101) || (funct == 6'b100000) ||
                      (funct == 6'b100010) || (funct == 6'b011000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            funct_q   <= FN_ADD;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                funct_q <= funct;
            if (state_d == S_HALT)
                illegal_q <= 1'b1;
            // HALT never returns to FETCH, so illegal instructions are never counted
            if (state_d == S_FETCH && state_q != S_FETCH)
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_op      = 2'b00;
        alu_funct   = FN_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        iord        = 1'b0;
        pc_src      = 2'b00;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'b01;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_d = funct_ok ? S_EXEC : S_HALT;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDI_EX;
                    default:       state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                iord       = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                iord        = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                alu_funct = funct_q;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst     = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write_c = ZERO;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Gating on rst makes enables drop the instant reset asserts, not at the next edge
    assign pc_write  = pc_write_c  & ~rst;
    assign ir_write  = ir_write_c  & ~rst;
    assign mem_read  = mem_read_c  & ~rst;
    assign mem_write = mem_write_c & ~rst;
    assign reg_write = reg_write_c & ~rst;
    assign state     = state_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: state sequences, control outputs, stalls,
// illegal halt, counter wrap (4-bit counter) and asynchronous reset.
module tb_mips_mc_control;

    logic       clk, rst;
    logic [5:0] opcode, funct;
    logic       ZERO, mem_ready;
    logic [1:0] alu_op, alu_src_b, pc_src;
    logic [5:0] alu_funct;
    logic       alu_src_a, iord, mem_read, mem_write, ir_write, pc_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal;
    logic [3:0] state;
    logic [3:0] retired;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         irw_cnt, mw_cnt, en_cnt;
    logic [3:0] exp_ret;

    mips_mc_control #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .ZERO(ZERO),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_funct(alu_funct),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive mem_ready at the falling edge, then check the state.
    task automatic step(input logic [3:0] es, input logic mr);
        @(negedge clk);
        mem_ready = mr;
        #1;
        chk("state", 32'(state), 32'(es));
        irw_cnt += 32'(ir_write);
        mw_cnt  += 32'(mem_write);
        en_cnt  += 32'(pc_write) + 32'(ir_write) + 32'(mem_read) + 32'(mem_write) + 32'(reg_write);
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input logic mr);
        opcode = op;
        funct  = fn;
        step(4'd0, mr);
        chk("retired", 32'(retired), 32'(exp_ret));
    endtask

    task automatic run_add();
        fetch(6'b000000, 6'b100000, 1'b1);
        step(4'd1, 1'b1);
        step(4'd6, 1'b1);
        step(4'd7, 1'b1);
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 4'd0;
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = 6'd0; funct = 6'b100010; ZERO = 1'b0;
        irw_cnt = 0; mw_cnt = 0; en_cnt = 0; exp_ret = 4'd0;

        // reset state, enables forced low while rst is high
        @(negedge clk); #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_alu_funct", 32'(alu_funct), 32'h20);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("fetch_mem_read", 32'(mem_read), 32'd1);

        // R-type sub
        fetch(6'b000000, 6'b100010, 1'b1);
        chk("fetch_ir_write", 32'(ir_write), 32'd1);
        chk("fetch_pc_write", 32'(pc_write), 32'd1);
        chk("fetch_src_b", 32'(alu_src_b), 32'd1);
        step(4'd1, 1'b1);
        chk("decode_src_b", 32'(alu_src_b), 32'd3);
        chk("decode_alu_op", 32'(alu_op), 32'd0);
        step(4'd6, 1'b1);
        funct = 6'b000000;
        #1;
        chk("exec_alu_op", 32'(alu_op), 32'd2);
        chk("exec_alu_funct", 32'(alu_funct), 32'h22);
        chk("exec_src_a", 32'(alu_src_a), 32'd1);
        step(4'd7, 1'b1);
        chk("rwb_reg_write", 32'(reg_write), 32'd1);
        chk("rwb_reg_dst", 32'(reg_dst), 32'd1);
        chk("rwb_alu_funct", 32'(alu_funct), 32'h20);
        exp_ret = exp_ret + 4'd1;

        // lw with 2 fetch stalls and 3 memory-read stalls: 10 cycles
        irw_cnt = 0;
        fetch(6'b100011, 6'b000000, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b1);
        step(4'd1, 1'b1);
        step(4'd2, 1'b1);
        chk("memaddr_src_b", 32'(alu_src_b), 32'd2);
        step(4'd3, 1'b0);
        chk("memrd_iord", 32'(iord), 32'd1);
        chk("memrd_mem_read", 32'(mem_read), 32'd1);
        step(4'd3, 1'b0);
        step(4'd3, 1'b0);
        step(4'd3, 1'b1);
        step(4'd4, 1'b1);
        chk("memwb_mem_to_reg", 32'(mem_to_reg), 32'd1);
        chk("memwb_reg_write", 32'(reg_write), 32'd1);
        chk("lw_ir_write_pulses", 32'(irw_cnt), 32'd1);
        exp_ret = exp_ret + 4'd1;

        // beq taken then not taken
        fetch(6'b000100, 6'b000000, 1'b1);
        step(4'd1, 1'b1);
        ZERO = 1'b1;
        step(4'd8, 1'b1);
        chk("beq_t_pc_write", 32'(pc_write), 32'd1);
        chk("beq_t_pc_src", 32'(pc_src), 32'd1);
        chk("beq_t_alu_op", 32'(alu_op), 32'd1);
        exp_ret = exp_ret + 4'd1;
        fetch(6'b000100, 6'b000000, 1'b1);
        step(4'd1, 1'b1);
        ZERO = 1'b0;
        step(4'd8, 1'b1);
        chk("beq_nt_pc_write", 32'(pc_write), 32'd0);
        exp_ret = exp_ret + 4'd1;

        // sw, j, addi back-to-back
        mw_cnt = 0;
        fetch(6'b101011, 6'b000000, 1'b1);
        step(4'd1, 1'b1);
        step(4'd2, 1'b1);
        step(4'd5, 1'b1);
        chk("memwr_iord", 32'(iord), 32'd1);
        exp_ret = exp_ret + 4'd1;
        fetch(6'b000010, 6'b000000, 1'b1);
        step(4'd1, 1'b1);
        step(4'd9, 1'b1);
        chk("jump_pc_src", 32'(pc_src), 32'd2);
        chk("jump_pc_write", 32'(pc_write), 32'd1);
        exp_ret = exp_ret + 4'd1;
        fetch(6'b001000, 6'b000000, 1'b1);
        step(4'd1, 1'b1);
        step(4'd10, 1'b1);
        chk("addiex_src_b", 32'(alu_src_b), 32'd2);
        chk("addiex_src_a", 32'(alu_src_a), 32'd1);
        step(4'd11, 1'b1);
        chk("addiwb_reg_write", 32'(reg_write), 32'd1);
        chk("addiwb_reg_dst", 32'(reg_dst), 32'd0);
        chk("addiwb_mem_to_reg", 32'(mem_to_reg), 32'd0);
        chk("sw_mem_write_cycles", 32'(mw_cnt), 32'd1);
        exp_ret = exp_ret + 4'd1;

        // sw with one write stall: mem_write held through the wait
        fetch(6'b101011, 6'b000000, 1'b1);
        step(4'd1, 1'b1);
        step(4'd2, 1'b1);
        step(4'd5, 1'b0);
        chk("memwr_stall_write", 32'(mem_write), 32'd1);
        step(4'd5, 1'b1);
        exp_ret = exp_ret + 4'd1;

        // run adds until the 4-bit counter wraps to zero
        for (int k = 0; k < 16 && exp_ret != 4'd0; k++)
            run_add();
        fetch(6'b000000, 6'b100000, 1'b0);
        chk("wrap_retired_zero", 32'(retired), 32'd0);

        // illegal opcode
        fetch(6'b111111, 6'b000000, 1'b1);
        step(4'd1, 1'b1);
        en_cnt = 0;
        for (int k = 0; k < 20; k++) step(4'd15, 1'b1);
        chk("halt_op_illegal", 32'(illegal), 32'd1);
        chk("halt_op_enables", 32'(en_cnt), 32'd0);
        chk("halt_op_retired", 32'(retired), 32'(exp_ret));
        do_reset();

        // addi then illegal R-type funct
        fetch(6'b001000, 6'b000000, 1'b1);
        step(4'd1, 1'b1);
        step(4'd10, 1'b1);
        step(4'd11, 1'b1);
        exp_ret = exp_ret + 4'd1;
        fetch(6'b000000, 6'b000111, 1'b1);
        step(4'd1, 1'b1);
        en_cnt = 0;
        for (int k = 0; k < 20; k++) step(4'd15, 1'b1);
        chk("halt_fn_illegal", 32'(illegal), 32'd1);
        chk("halt_fn_enables", 32'(en_cnt), 32'd0);
        chk("halt_fn_retired", 32'(retired), 32'd1);
        do_reset();
        #1;
        chk("rst_clears_illegal", 32'(illegal), 32'd0);

        // asynchronous reset in MEM_RD
        fetch(6'b100011, 6'b000000, 1'b1);
        step(4'd1, 1'b1);
        step(4'd2, 1'b1);
        step(4'd3, 1'b0);
        chk("pre_arst_mem_read", 32'(mem_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_mem_read", 32'(mem_read), 32'd0);
        chk("arst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
